// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: datapath width
// default, FSM state encodings and operation codes.
package multdiv_unit_pkg;

    // Operand/result width shared with the register file.
    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_e;

endpackage

// File: rtl/multdiv_unit_twos_mag.sv
// twos_mag: combinational conditional two's-complement negate.
// Used as abs() on sign-extended operands and as the final sign correction.
//   i_val  in  N  value to convert
//   i_neg  in  1  negate when high
//   o_val  out N  i_neg ? -i_val : i_val
module twos_mag #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] i_val,
    input  logic         i_neg,
    output logic [N-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + N'(1)) : i_val;

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply/divide, one radix-2 step per clock,
// a single shift/accumulate register shared by both operations.
//   clock           in   1      rising-edge clock
//   ctrl_reset_n    in   1      async active-low reset
//   ctrl_MULT       in   1      start multiply (sampled in IDLE/DONE); wins over DIV
//   ctrl_DIV        in   1      start divide (sampled in IDLE/DONE)
//   data_operandA   in   WIDTH  multiplicand / dividend
//   data_operandB   in   WIDTH  multiplier / divisor
//   data_result     out  WIDTH  product low half / quotient, held until next completion
//   data_exception  out  1      overflow or divide-by-zero, held like data_result
//   data_resultRDY  out  1      one-cycle completion pulse (the DONE cycle)
//   busy            out  1      operation in progress (RUN and DONE)
module multdiv_unit
    import multdiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned MW = WIDTH + 1;      // magnitude width: holds 2^(W-1)
    localparam int unsigned AW = 2 * WIDTH + 1;  // {hi[MW], lo[WIDTH]}

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [MW-1:0]    r_mag_b;
    md_op_e           r_op;
    logic             r_neg;
    logic             r_bzero;

    logic             w_start;
    logic             w_last;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic [MW-1:0]    w_a_ext;
    logic [MW-1:0]    w_b_ext;
    logic [MW-1:0]    w_mag_a;
    logic [MW-1:0]    w_mag_b;
    logic [AW-1:0]    w_acc_init;
    logic [MW-1:0]    w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [MW-1:0]    w_addend;
    logic [MW:0]      w_sum;
    logic [MW-1:0]    w_trial;
    logic [MW:0]      w_diff;
    logic             w_borrow;
    logic [AW-1:0]    w_mul_nxt;
    logic [AW-1:0]    w_div_nxt;
    logic [AW-1:0]    w_acc_nxt;
    logic [AW-1:0]    w_corr_in;
    logic [AW-1:0]    w_corr;
    logic [WIDTH+1:0] w_top;
    logic             w_ovf;
    logic             w_div0;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    // Operand magnitudes, widened by one bit so -2^(W-1) does not wrap.
    assign w_a_ext = {data_operandA[WIDTH-1], data_operandA};
    assign w_b_ext = {data_operandB[WIDTH-1], data_operandB};

    twos_mag #(.N(MW)) u_mag_a (
        .i_val (w_a_ext),
        .i_neg (data_operandA[WIDTH-1]),
        .o_val (w_mag_a)
    );

    twos_mag #(.N(MW)) u_mag_b (
        .i_val (w_b_ext),
        .i_neg (data_operandB[WIDTH-1]),
        .o_val (w_mag_b)
    );

    // Bit W of |A| is pre-processed at load so only W iterations remain:
    // for multiply it contributes |B|<<W, for divide it seeds the remainder.
    assign w_acc_init = ctrl_MULT
                      ? {(w_mag_a[WIDTH] ? w_mag_b : MW'(0)), w_mag_a[WIDTH-1:0]}
                      : {WIDTH'(0), w_mag_a};

    // One shift-add (multiply) or restoring-subtract (divide) step.
    assign w_hi      = r_acc[AW-1:WIDTH];
    assign w_lo      = r_acc[WIDTH-1:0];
    assign w_addend  = w_lo[0] ? r_mag_b : '0;
    assign w_sum     = {1'b0, w_hi} + {1'b0, w_addend};
    assign w_mul_nxt = {w_sum, w_lo[WIDTH-1:1]};
    assign w_trial   = {w_hi[WIDTH-1:0], w_lo[WIDTH-1]};
    assign w_diff    = {1'b0, w_trial} - {1'b0, r_mag_b};
    assign w_borrow  = w_diff[MW];
    assign w_div_nxt = {(w_borrow ? w_trial : w_diff[MW-1:0]), w_lo[WIDTH-2:0], ~w_borrow};
    assign w_acc_nxt = (r_op == OP_DIV) ? w_div_nxt : w_mul_nxt;

    // Sign correction of the final product / quotient.
    assign w_corr_in = (r_op == OP_DIV) ? AW'(w_acc_nxt[WIDTH-1:0]) : w_acc_nxt;

    twos_mag #(.N(AW)) u_corr (
        .i_val (w_corr_in),
        .i_neg (r_neg),
        .o_val (w_corr)
    );

    // Out of signed W-bit range when the bits above the result sign disagree.
    assign w_top  = w_corr[AW-1:WIDTH-1];
    assign w_ovf  = ~((&w_top) | ~(|w_top));
    assign w_div0 = (r_op == OP_DIV) & r_bzero;

    // State register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE may chain straight into the next operation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = w_start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath control decode.
    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: w_load = w_start;
            ST_RUN: begin
                w_step   = 1'b1;
                w_finish = w_last;
            end
            ST_DONE: w_load = w_start;
            default: ;
        endcase
    end

    // Operand capture, iteration, counter and registered outputs.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_cnt          <= '0;
            r_acc          <= '0;
            r_mag_b        <= '0;
            r_op           <= OP_MULT;
            r_neg          <= 1'b0;
            r_bzero        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            if (w_load) begin
                r_acc   <= w_acc_init;
                r_mag_b <= w_mag_b;
                r_op    <= ctrl_MULT ? OP_MULT : OP_DIV;
                r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_bzero <= (data_operandB == '0);
                r_cnt   <= '0;
            end else if (w_step) begin
                r_acc <= w_acc_nxt;
                if (!w_last) r_cnt <= r_cnt + CW'(1);
            end
            if (w_finish) begin
                data_result    <= w_div0 ? '0 : w_corr[WIDTH-1:0];
                data_exception <= w_div0 | w_ovf;
            end
            data_resultRDY <= w_finish;
            busy           <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes hand-computed expected
// results, a negedge monitor pops and compares on every data_resultRDY.
module tb_multdiv_unit;

    localparam int unsigned W = 32;
    // Edges from the start edge to the edge entering DONE; counting the start
    // cycle itself, ready is seen in the 33rd cycle.
    localparam int LAT = 32;

    logic         clock;
    logic         ctrl_reset_n;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .ctrl_reset_n   (ctrl_reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic fail_bound(input string name);
        n_tot++;
        $display("FAIL %s: actual=timeout required=event within bound", name);
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (ctrl_reset_n === 1'b1 && data_resultRDY === 1'b1) begin
            if (q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_rdy: actual result=%h required no completion", data_result);
            end else begin : pop
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_res"}, data_result, e.res);
                chk({e.name, "_exc"}, 32'(data_exception), 32'(e.exc));
                chk({e.name, "_lat"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_busy"}, 32'(busy), 32'd1);
            end
        end
    end

    // Issue one start; waits (bounded) until the unit is idle or in DONE.
    task automatic do_op(input string name, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee, input bit push);
        int n = 0;
        while (!(busy === 1'b0 || data_resultRDY === 1'b1) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) fail_bound({name, "_issue"});
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        if (push) q.push_back('{res: er, exc: ee, cyc: cyc + LAT, name: name});
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy !== 1'b0 || q.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) fail_bound(name);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_result"}, data_result, 32'h0);
        chk({name, "_exc"},    32'(data_exception), 32'h0);
        chk({name, "_rdy"},    32'(data_resultRDY), 32'h0);
        chk({name, "_busy"},   32'(busy), 32'h0);
    endtask

    initial begin
        ctrl_reset_n  = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        chk_zero_outputs("reset");
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(negedge clock);

        // Directed vectors, issued back-to-back (each start lands in DONE).
        do_op("mul_7_m6",      1, 0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, 1);
        do_op("mul_ovf_2p32",  1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 1);
        do_op("div_m7_2",      0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 1);
        do_op("div_100_7",     0, 1, 32'd100,       32'd7,         32'd14,        0, 1);
        do_op("div_5_0",       0, 1, 32'd5,         32'd0,         32'h0,         1, 1);
        do_op("div_min_m1",    0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        do_op("both_10_3",     1, 1, 32'd10,        32'd3,         32'd30,        0, 1);
        do_op("mul_min_1",     1, 0, 32'h8000_0000, 32'd1,         32'h8000_0000, 0, 1);
        do_op("mul_min_m1",    1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        do_op("div_min_1",     0, 1, 32'h8000_0000, 32'd1,         32'h8000_0000, 0, 1);
        do_op("mul_max_max",   1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1, 1);
        do_op("mul_2p30_2",    1, 0, 32'h4000_0000, 32'd2,         32'h8000_0000, 1, 1);
        do_op("mul_m2p30_2",   1, 0, 32'hC000_0000, 32'd2,         32'h8000_0000, 0, 1);
        do_op("mul_m1_m1",     1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         0, 1);
        do_op("div_3_5",       0, 1, 32'd3,         32'd5,         32'd0,         0, 1);
        do_op("div_0_m9",      0, 1, 32'd0,         32'hFFFF_FFF7, 32'd0,         0, 1);

        // Start pulse while busy (with new operands) must be ignored.
        wait_idle("pre_ignore");
        do_op("div_12_4", 0, 1, 32'd12, 32'd4, 32'd3, 0, 1);
        repeat (5) @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_idle("ignore_drain");

        // Result and exception hold while idle.
        repeat (5) @(negedge clock);
        chk("hold_result", data_result, 32'd3);
        chk("hold_exc", 32'(data_exception), 32'h0);

        // Start in the cycle after DONE is accepted.
        do_op("mul_5_m1", 1, 0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0, 1);
        begin
            int n = 0;
            while (data_resultRDY !== 1'b1 && n < 100) begin
                @(negedge clock);
                n++;
            end
            if (n >= 100) fail_bound("after_done_wait");
        end
        @(negedge clock);
        do_op("div_m100_7", 0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 1);

        // Reset mid-RUN: outputs clear at once, no completion afterwards.
        wait_idle("pre_abort");
        do_op("abort", 1, 0, 32'd1234, 32'd5678, 32'h0, 0, 0);
        repeat (10) @(negedge clock);
        ctrl_reset_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        repeat (40) @(negedge clock);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=time limit reached required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
